// File: rtl/note_sequencer_if.sv
// Control, pattern-write and playback signals between the step sequencer and its host.
interface note_sequencer_if #(
    parameter int unsigned STEPS_LOG2 = 3
);
    logic                  run;
    logic [7:0]            tempo;
    logic [STEPS_LOG2-1:0] last_step;
    logic                  wr_en;
    logic [STEPS_LOG2-1:0] wr_addr;
    logic [16:0]           wr_data;
    logic [11:0]           osc_count;
    logic                  trig;
    logic [STEPS_LOG2-1:0] step;
    logic                  busy;
    logic                  done;

    modport master (
        output run, tempo, last_step, wr_en, wr_addr, wr_data,
        input  osc_count, trig, step, busy, done
    );

    modport slave (
        input  run, tempo, last_step, wr_en, wr_addr, wr_data,
        output osc_count, trig, step, busy, done
    );
endinterface

// File: rtl/note_sequencer.sv
// Step sequencer: plays a note/gate pattern as osc_count + ADSR trig for the synth voice.
// Define SEQ_LOOP_EN to wrap after last_step instead of stopping with a done pulse.
//
// state  | meaning
// S_IDLE | stopped, trig low, osc_count holds
// S_LOAD | one cycle: fetch the step, drive note/trig/step
// S_PLAY | count ticks, drop trig at gate end, advance at step end
module note_sequencer #(
    parameter int unsigned PRESCALE   = 262144,
    parameter int unsigned STEPS_LOG2 = 3
) (
    input  logic            clk,
    input  logic            rstn,
    note_sequencer_if.slave bus
);
    localparam int unsigned PW    = $clog2(PRESCALE);
    localparam int unsigned DEPTH = 1 << STEPS_LOG2;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [STEPS_LOG2-1:0] ptr_q, ptr_d;
    logic [STEPS_LOG2-1:0] step_q, step_d;
    logic [11:0]           osc_q, osc_d;
    logic [3:0]            gate_q, gate_d;
    logic                  trig_q, trig_d;
    logic                  done_q, done_d;
    logic                  hold_q, hold_d;
    logic [16:0]           mem_q [DEPTH];

    logic        tick;
    logic        tie;
    logic        is_last;
    logic [7:0]  tempo_eff;
    logic [7:0]  gate_eff;
    logic [7:0]  cnt_inc;
    logic [16:0] cur;

    always_comb begin
        tick      = (presc_q == PRE_LAST);
        tempo_eff = (bus.tempo == 8'd0) ? 8'd1 : bus.tempo;
        gate_eff  = ({4'd0, gate_q} >= tempo_eff) ? (tempo_eff - 8'd1) : {4'd0, gate_q};
        tie       = (gate_q == 4'hF) && (tempo_eff > 8'd15);
        cnt_inc   = cnt_q + 8'd1;
        is_last   = (ptr_q >= bus.last_step);
        cur       = mem_q[ptr_q];

        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        step_d  = step_q;
        osc_d   = osc_q;
        gate_d  = gate_q;
        trig_d  = trig_q;
        done_d  = 1'b0;
        hold_d  = hold_q;

        // A one-shot finish keeps the block parked until run is released.
        if (!bus.run) hold_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                trig_d = 1'b0;
                if (bus.run && !hold_q) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    presc_d = '0;
                end
            end
            S_LOAD: begin
                if (!bus.run) begin
                    state_d = S_IDLE;
                    trig_d  = 1'b0;
                end else begin
                    osc_d   = cur[11:0];
                    gate_d  = cur[15:12];
                    trig_d  = !cur[16] && (cur[15:12] != 4'd0);
                    step_d  = ptr_q;
                    cnt_d   = 8'd0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!bus.run) begin
                    state_d = S_IDLE;
                    trig_d  = 1'b0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (!tie && (cnt_inc == gate_eff)) trig_d = 1'b0;
                    if (cnt_inc == tempo_eff) begin
                        if (!is_last) begin
                            ptr_d   = ptr_q + STEPS_LOG2'(1);
                            state_d = S_LOAD;
                        end else begin
`ifdef SEQ_LOOP_EN
                            ptr_d   = '0;
                            state_d = S_LOAD;
`else
                            state_d = S_IDLE;
                            trig_d  = 1'b0;
                            done_d  = 1'b1;
                            hold_d  = 1'b1;
`endif
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= 8'd0;
            ptr_q   <= '0;
            step_q  <= '0;
            osc_q   <= 12'd0;
            gate_q  <= 4'd0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            osc_q   <= osc_d;
            gate_q  <= gate_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    // Pattern memory survives reset so a pattern can be replayed after a reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    end

    assign bus.osc_count = osc_q;
    assign bus.trig      = trig_q;
    assign bus.step      = step_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed cases plus random patterns vs a timeline model.
module tb_note_sequencer;
    localparam int P  = 4;
    localparam int SL = 3;
    localparam int NS = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    note_sequencer_if #(.STEPS_LOG2(SL)) bus ();

    note_sequencer #(.PRESCALE(P), .STEPS_LOG2(SL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [16:0] pat  [NS];
    logic [16:0] snap [NS];
    int prev_osc;
    int prev_step;
    int tempo_t;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs just after the r-th posedge counted from the edge that sampled run=1.
    // A step lasts P*T clocks; step i is visible from edge P*T*i+1 to P*T*(i+1).
    function automatic void model(input int r, input int n,
                                  output int e_osc, output int e_trig, output int e_step,
                                  output int e_busy, output int e_done);
        int t, len, i, k, g, geff, idx;
        logic [16:0] src;
        t      = (tempo_t == 0) ? 1 : tempo_t;
        len    = P * t;
        e_done = 0;
        if (r == 0) begin
            e_osc = prev_osc; e_step = prev_step; e_trig = 0; e_busy = 1;
            return;
        end
`ifndef SEQ_LOOP_EN
        if (r >= len * n) begin
            e_osc  = int'(snap[n-1][11:0]);
            e_step = n - 1;
            e_trig = 0;
            e_busy = 0;
            e_done = (r == len * n) ? 1 : 0;
            return;
        end
`endif
        i    = (r - 1) / len;
        k    = (r - len * i) / P;
        idx  = i % n;
        src  = (i >= n) ? pat[idx] : snap[idx];
        g    = int'(src[15:12]);
        geff = (g < t - 1) ? g : t - 1;
        e_osc  = int'(src[11:0]);
        e_step = idx;
        e_busy = 1;
        e_trig = (!src[16] && g != 0 && ((g == 15 && t > 15) || t == 1 || k < geff)) ? 1 : 0;
    endfunction

    task automatic wr(input int a, input logic [16:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[SL-1:0];
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        pat[a] = d;
    endtask

    task automatic cfg(input int t, input int last);
        tempo_t       = t;
        bus.tempo     = 8'(t);
        bus.last_step = SL'(last);
    endtask

    task automatic chk_outs(input string pfx, input int eo, input int et, input int es,
                            input int eb, input int ed);
        chk_eq({pfx, "_osc"},  32'(bus.osc_count), eo);
        chk_eq({pfx, "_trig"}, 32'(bus.trig), et);
        chk_eq({pfx, "_step"}, 32'(bus.step), es);
        chk_eq({pfx, "_busy"}, 32'(bus.busy), eb);
        chk_eq({pfx, "_done"}, 32'(bus.done), ed);
    endtask

    task automatic play(input int n, input int stop_r, input int lw_r, input logic [16:0] lw_val,
                        input int chg_r, input int chg_val);
        int t, len, last_r;
        int eo, et, es, eb, ed;
        t   = (tempo_t == 0) ? 1 : tempo_t;
        len = P * t;
        for (int j = 0; j < NS; j++) snap[j] = pat[j];
`ifdef SEQ_LOOP_EN
        if (stop_r < 0) stop_r = len * (n + 1) + 3;
`endif
        last_r = (stop_r >= 0) ? stop_r : len * n + 1;
        @(negedge clk);
        bus.run = 1'b1;
        for (int r = 0; r <= last_r; r++) begin
            @(posedge clk);
            #1;
            bus.wr_en = 1'b0;
            model(r, n, eo, et, es, eb, ed);
            chk_outs("play", eo, et, es, eb, ed);
            if (r == lw_r) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = '0;
                bus.wr_data = lw_val;
                pat[0]      = lw_val;
            end
            if (r == chg_r) bus.last_step = SL'(chg_val);
        end
        bus.wr_en = 1'b0;
        if (stop_r >= 0) begin
            bus.run = 1'b0;
            repeat (2) begin
                @(posedge clk);
                #1;
                chk_outs("stop", eo, 0, es, 0, 0);
            end
        end else begin
            repeat (4) begin
                @(posedge clk);
                #1;
                chk_eq("rearm_busy", 32'(bus.busy), 0);
                chk_eq("rearm_done", 32'(bus.done), 0);
            end
            bus.run = 1'b0;
            @(posedge clk);
            #1;
        end
        prev_osc  = eo;
        prev_step = es;
    endtask

    initial begin
        int t, last;
        logic [16:0] d;
        bus.run = 1'b0; bus.tempo = 8'd0; bus.last_step = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 17'd0;
        tempo_t = 0; prev_osc = 0; prev_step = 0;
        for (int j = 0; j < NS; j++) pat[j] = 17'd0;

        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic single step, one-shot.
        wr(0, {1'b0, 4'd2, 12'h123});
        cfg(4, 0);
        play(1, -1, -1, 17'd0, -1, 0);

        // Reset while trig is high, then replay from preserved memory.
        @(negedge clk);
        bus.run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk_eq("pre_rst_trig", 32'(bus.trig), 1);
        rstn    = 1'b0;
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("mid_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        prev_osc = 0; prev_step = 0;
        play(1, -1, -1, 17'd0, -1, 0);

        // Rest step then gate clamped to T-1.
        wr(0, {1'b1, 4'd5, 12'h0AA});
        wr(1, {1'b0, 4'd9, 12'h200});
        cfg(3, 1);
        play(2, -1, -1, 17'd0, -1, 0);

        // Tie at T=1, then tempo 0 treated as 1 with mixed gates.
        for (int j = 0; j < 3; j++) wr(j, {1'b0, 4'd15, 12'(12'h101 * (j + 1))});
        cfg(1, 2);
        play(3, -1, -1, 17'd0, -1, 0);
        wr(1, {1'b0, 4'd3, 12'h777});
        cfg(0, 2);
        play(3, -1, -1, 17'd0, -1, 0);

        // Stop during step 1.
        wr(0, {1'b0, 4'd1, 12'h010});
        wr(1, {1'b0, 4'd1, 12'h020});
        wr(2, {1'b0, 4'd1, 12'h030});
        cfg(2, 2);
        play(3, P * 2 + 3, -1, 17'd0, -1, 0);

        // Live write to the playing step: heard on the next pass only.
        cfg(2, 1);
        play(2, -1, 2, {1'b0, 4'd1, 12'hABC}, -1, 0);
        play(2, -1, -1, 17'd0, -1, 0);

`ifndef SEQ_LOOP_EN
        // last_step lowered below the playing step ends the pattern there.
        for (int j = 0; j < 6; j++) wr(j, {1'b0, 4'd1, 12'(12'h040 + j)});
        cfg(2, 5);
        play(4, -1, -1, 17'd0, 3 * P * 2 + 2, 1);
`endif

        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < NS; j++) begin
                d = {($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), 12'($urandom)};
                wr(j, d);
            end
            t = int'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) t = int'($urandom_range(15, 17));
            last = int'($urandom_range(0, NS - 1));
            cfg(t, last);
            if (it % 2 == 1)
                play(last + 1, int'($urandom_range(1, P * ((t == 0) ? 1 : t) * (last + 1) - 1)),
                     -1, 17'd0, -1, 0);
            else
                play(last + 1, -1, -1, 17'd0, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Step sequencer that drives the synth voice: plays an 8-step pattern of notes by sequencing the oscillator period (osc_count) and the ADSR trigger (trig). Sits upstream of synth in the top level, in the 20.48 MHz clk domain. Generates its own step tick from a prescaler. Holds trig for whole ticks, long enough for the slow-clock trigger synchronizer downstream.

Parameters:
PRESCALE, 262144, clk cycles per sequencer tick (default gives 78.125 Hz at 20.48 MHz, matching the ADSR rate); min 2
STEPS_LOG2, 3, log2 of pattern depth (8 steps)

Ports:
clk  in  1  system clock, 20.48 MHz
rstn  in  1  reset, synchronous, active-low
run  in  1  level; 1 = play pattern, 0 = stop
tempo  in  8  ticks per step; 0 treated as 1
last_step  in  STEPS_LOG2  index of final step in pattern
wr_en  in  1  pattern memory write strobe
wr_addr  in  STEPS_LOG2  step index to write
wr_data  in  17  {rest[16], gate[15:12], note[11:0]}
osc_count  out  12  oscillator period for the current note
trig  out  1  ADSR gate
step  out  STEPS_LOG2  index of the step currently playing
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when a one-shot pattern completes

Behaviour:
- Reset (rstn=0 at posedge clk): osc_count=0, trig=0, step=0, busy=0, done=0, prescaler=0, tick counter=0, state=IDLE. Pattern memory is not cleared. Reset overrides all other inputs, including mid-step.
- Pattern memory: 2^STEPS_LOG2 x 17-bit registers. Written at the posedge where wr_en=1; legal in any state. A write to the playing step takes effect only when that step is next loaded.
- Prescaler: counts 0..PRESCALE-1 and asserts internal tick for one cycle at PRESCALE-1. Cleared on the start transition.
- States:
  - IDLE
    - run=1 -> LOAD with step=0, prescaler cleared.
    - Otherwise trig=0 and osc_count holds its last value.
  - LOAD (1 cycle)
    - Sets osc_count=note[step].
    - Sets trig = !rest && gate!=0.
    - Clears the tick counter.
    - Moves to PLAY.
  - PLAY, on each tick:
    - Increment the tick counter.
    - When counter+1 == gate_eff, trig goes to 0. gate_eff = min(gate, T-1), where T = max(tempo,1).
    - When counter+1 == T, the step ends.
      - If step != last_step: step increments, go to LOAD.
      - Else, without loop (see Optional Feature): go to IDLE and pulse done.
  - Any state except IDLE: run=0 -> IDLE next cycle, trig=0, no done pulse, step holds its value.
- Tie: gate=15 with T>15 is held for the whole step. Gate=15 when T<=15 still clamps to T-1. If the clamp would leave 0 low ticks (T=1), trig stays 1 and that step does not retrigger.
- Latency: osc_count/trig/step change exactly 2 cycles after the tick that ends the previous step. On start, the change comes 2 cycles after the run=1 edge sample.
- last_step is sampled only at step end. If step > last_step at that time, the step end is treated as the last step.
- busy = (state != IDLE). done and the IDLE transition happen in the same cycle.
- Simultaneous run=0 and step end: run=0 wins; no done pulse.

Optional Feature:
Macro SEQ_LOOP_EN.
- Defined: at the end of last_step with run=1, step wraps to 0 and goes to LOAD. No gap beyond the LOAD cycle, and done never pulses.
- Undefined: one-shot. After last_step the block goes to IDLE and pulses done; run must drop to 0 and rise again to restart. run held high while in IDLE after done does not restart.

Test Plan:
- Common setup: PRESCALE=4.
- Reset mid-PLAY: pulse rstn=0 for 1 cycle while trig=1 -> next cycle trig=0, osc_count=0, step=0, busy=0; pattern memory contents preserved on replay.
- Basic step: write step0={0,4'd2,12'h123}, last_step=0, tempo=4, run=1 -> osc_count=0x123 2 cycles after start; trig high for 2 ticks (8 clk), low 2 ticks; then done pulse, busy=0 (loop undefined).
- Rest and gate clamp: step0 rest=1 gate=5, step1 gate=9 note 0x200, tempo=3 -> trig 0 throughout step0; step1 trig high exactly 2 ticks (clamped to T-1), low 1 tick.
- Tie: tempo=1, gate=15 on steps 0..2 -> trig stays 1 across step boundaries; osc_count changes each tick.
- Loop: with SEQ_LOOP_EN, last_step=2 -> step sequence 0,1,2,0,1; done never asserts. Without the macro: stops after step 2 with a single done pulse.
- Stop and live write: run=0 during step 1 -> IDLE next cycle, trig=0, no done. Write step0 while step0 is playing -> new note heard only on the next pass.
